sr_excitation_driver: RTL and testbench
=======================================

# sr_excitation_driver

Drives a set/reset flip-flop in the opposite direction to the flop itself. The flop turns S/R commands into a state q; this block accepts target q values over a valid/ready handshake and computes the S/R excitation for each one. It drives s/r for a programmable number of cycles, then confirms the flop's q feedback reached the target within a timeout. It sits between control logic and any SR flop in the design, never issues the illegal S=R=1 code, and counts flops that fail to follow.

## Interface
Parameters:
- HOLD_CYCLES, default 1: cycles s or r is held asserted per transition; legal range ≥1.
- TIMEOUT, default 4: CHECK cycles allowed for q_fb to match; legal range ≥1.
- CNT_W, default 8: width of err_cnt.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  reset, synchronous and active-high.
- tgt_valid  in  1  target value offered.
- tgt_d  in  1  target q value.
- tgt_ready  out  1  block accepts a target; equals (state==IDLE).
- s  out  1  set command to the flop; registered.
- r  out  1  reset command to the flop; registered.
- q_fb  in  1  q from the driven flop, same clock domain.
- busy  out  1  state≠IDLE.
- done  out  1  one-cycle pulse: target reached.
- err  out  1  one-cycle pulse: timeout, q_fb never matched.
- err_cnt  out  CNT_W  saturating count of err pulses.
- model_q  out  1  block's tracked value of flop q.

## Operation
- State machine states: IDLE, DRIVE, CHECK.
- **IDLE**
  - tgt_ready=1.
  - A target is accepted on any edge where tgt_valid & tgt_ready. The target is latched into tgt_q.
  - If tgt_d==model_q: no drive, s=r=0. done pulses next cycle and the state stays IDLE.
  - If tgt_d≠model_q: go to DRIVE with {s,r} = tgt_d ? 2'b10 : 2'b01, and load hold_cnt=HOLD_CYCLES-1.
- **DRIVE**
  - s/r stay asserted; hold_cnt decrements each cycle.
  - At hold_cnt==0: s=r=0 and go to CHECK, loading to_cnt=TIMEOUT-1.
- **CHECK**
  - s=r=0. q_fb is compared with tgt_q every cycle.
  - On match: done pulse, model_q<=tgt_q, go to IDLE.
  - Else if to_cnt==0: err pulse, err_cnt+1 (holds at 2^CNT_W-1), model_q<=q_fb (resync), go to IDLE.
  - Else: to_cnt decrements.
- Invariant: s&r==0 in every cycle, including the reset cycle.
- tgt_valid in DRIVE/CHECK is ignored (ready=0). The source holds tgt_d stable until accepted.
- rst is sampled at the edge and overrides everything, including mid-DRIVE or mid-CHECK:
  - state=IDLE.
  - s=r=0, done=err=0, err_cnt=0, model_q=0.
  - tgt_ready=1, busy=0.
  - model_q=0 matches the flop's reset value; the integrator resets both together.

## Timing
- Cycle n means the period after edge En. The accept edge is E0.
- Differing target, HOLD_CYCLES=H, conforming flop (q updates one edge after s/r sampled):
  - s or r high in cycles 1..H.
  - CHECK in cycle H+1, where q_fb already matches.
  - done high in cycle H+2, with tgt_ready=1 in the same cycle.
  - Total: accept-to-done latency H+2 cycles. Default is 3.
- Equal target: done high in cycle 1. Back-to-back accepts at one per cycle are allowed.
- Timeout path: err high in cycle H+TIMEOUT+1.
- done and err are mutually exclusive and last one cycle each.
- model_q updates on the same edge that raises done or err.

## Structure
- Package sr_drv_pkg:
  - typedef enum of the states IDLE/DRIVE/CHECK.
  - localparams SR_HOLD=2'b00, SR_RST=2'b01, SR_SET=2'b10, SR_ILLEGAL=2'b11.
- Sub-module sr_excite_enc: combinational encoder mapping (cur_q, tgt_q) → {s,r} using the package codes; never emits SR_ILLEGAL.
- Top level holds the FSM, hold_cnt/to_cnt sized $clog2(max(HOLD_CYCLES,TIMEOUT))+1, and the saturating err_cnt.

## Test plan
- **Reset values:** rst=1 for 2 cycles, then release. Required: s=r=0, done=err=0, err_cnt=0, model_q=0, tgt_ready=1, busy=0.
- **Set transition:** model_q=0, offer tgt_d=1 (H=1) with a conforming flop model. Required: s=1 in cycle 1 only, r=0 throughout, done in cycle 3, model_q=1.
- **Equal target:** model_q=1, offer tgt_d=1 on three consecutive cycles. Required: s=r=0 throughout, three consecutive done pulses, tgt_ready held at 1.
- **Timeout:** q_fb stuck at 0, offer tgt_d=1 (H=1, TIMEOUT=4). Required: err in cycle 6, err_cnt=1, model_q=0. Then repeat 256 times with CNT_W=8: err_cnt saturates at 255.
- **Reset mid-DRIVE:** with H=4, assert rst in cycle 2. Required: s drops to 0 on the next edge, state IDLE, no done or err, model_q=0.
- **Illegal-code assertion:** random tgt_valid/tgt_d/q_fb/rst for 10k cycles. Required: s&r never 1, and ready&busy never both 1.

Source files
------------

// File: rtl/sr_drv_pkg.sv
// rtl/sr_drv_pkg.sv - shared states, S/R command codes and helpers for the SR excitation driver
package sr_drv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    // {s, r} command codes
    localparam logic [1:0] SR_HOLD    = 2'b00;
    localparam logic [1:0] SR_RST     = 2'b01;
    localparam logic [1:0] SR_SET     = 2'b10;
    localparam logic [1:0] SR_ILLEGAL = 2'b11;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sr_excite_enc.sv
// rtl/sr_excite_enc.sv - maps (current q, target q) to the S/R excitation code
module sr_excite_enc
    import sr_drv_pkg::*;
(
    input  logic       cur_q,
    input  logic       tgt_q,
    output logic [1:0] sr_code
);

    logic [1:0] raw;

    // Excitation table of an SR flop; the final guard keeps S=R=1 off the wire
    always_comb begin
        raw = SR_HOLD;
        if (cur_q != tgt_q) begin
            raw = tgt_q ? SR_SET : SR_RST;
        end
        sr_code = (raw == SR_ILLEGAL) ? SR_HOLD : raw;
    end

endmodule

// File: rtl/sr_excitation_driver.sv
// rtl/sr_excitation_driver.sv - drives an SR flop toward accepted targets and checks q feedback
module sr_excitation_driver
    import sr_drv_pkg::*;
#(
    parameter int HOLD_CYCLES = 1,
    parameter int TIMEOUT     = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    input  logic             tgt_d,
    output logic             tgt_ready,
    output logic             s,
    output logic             r,
    input  logic             q_fb,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic             model_q
);

    localparam int CW = $clog2(max2(HOLD_CYCLES, TIMEOUT)) + 1;
    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] TO_LD   = CW'(TIMEOUT - 1);

    state_t        state;
    logic          tgt_q;
    logic [CW-1:0] hold_cnt;
    logic [CW-1:0] to_cnt;
    logic [1:0]    enc_sr;

    // Excitation is computed against our tracked q, not the live feedback
    sr_excite_enc u_enc (
        .cur_q   (model_q),
        .tgt_q   (tgt_d),
        .sr_code (enc_sr)
    );

    assign tgt_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // Accept / drive / verify sequencer with registered s, r and status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            s        <= 1'b0;
            r        <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_cnt  <= '0;
            model_q  <= 1'b0;
            tgt_q    <= 1'b0;
            hold_cnt <= '0;
            to_cnt   <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (tgt_valid) begin
                        tgt_q <= tgt_d;
                        if (enc_sr == SR_HOLD) begin
                            done <= 1'b1;
                        end else begin
                            {s, r}   <= enc_sr;
                            hold_cnt <= HOLD_LD;
                            state    <= DRIVE;
                        end
                    end
                end
                DRIVE: begin
                    if (hold_cnt == '0) begin
                        s      <= 1'b0;
                        r      <= 1'b0;
                        to_cnt <= TO_LD;
                        state  <= CHECK;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                CHECK: begin
                    if (q_fb == tgt_q) begin
                        done    <= 1'b1;
                        model_q <= tgt_q;
                        state   <= IDLE;
                    end else if (to_cnt == '0) begin
                        err <= 1'b1;
                        if (err_cnt != '1) begin
                            err_cnt <= err_cnt + 1'b1;
                        end
                        // Resync to what the flop actually holds
                        model_q <= q_fb;
                        state   <= IDLE;
                    end else begin
                        to_cnt <= to_cnt - 1'b1;
                    end
                end
                default: begin
                    s     <= 1'b0;
                    r     <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_excitation_driver.sv
// tb/tb_sr_excitation_driver.sv - self-checking bench for sr_excitation_driver
module tb_sr_excitation_driver;

    localparam int H  = 1;
    localparam int T  = 4;
    localparam int H4 = 4;

    logic       clk;
    logic       rst, tgt_valid, tgt_d, q_fb, stuck, fq;
    logic       tgt_ready, s, r, busy, done, err, model_q;
    logic [7:0] err_cnt;

    logic       rst4, tgt_valid4, tgt_d4, q_fb4, rnd_mode, rnd_q, fq4;
    logic       tgt_ready4, s4, r4, busy4, done4, err4, model_q4;
    logic [7:0] err_cnt4;

    int checks = 0;
    int errors = 0;

    sr_excitation_driver #(.HOLD_CYCLES(H), .TIMEOUT(T), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_d(tgt_d), .tgt_ready(tgt_ready),
        .s(s), .r(r), .q_fb(q_fb), .busy(busy), .done(done), .err(err),
        .err_cnt(err_cnt), .model_q(model_q)
    );

    sr_excitation_driver #(.HOLD_CYCLES(H4), .TIMEOUT(T), .CNT_W(8)) dut4 (
        .clk(clk), .rst(rst4), .tgt_valid(tgt_valid4), .tgt_d(tgt_d4), .tgt_ready(tgt_ready4),
        .s(s4), .r(r4), .q_fb(q_fb4), .busy(busy4), .done(done4), .err(err4),
        .err_cnt(err_cnt4), .model_q(model_q4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Conforming SR flops driven by each DUT
    always @(posedge clk) begin
        if (rst) fq <= 1'b0;
        else if (s) fq <= 1'b1;
        else if (r) fq <= 1'b0;
    end
    always @(posedge clk) begin
        if (rst4) fq4 <= 1'b0;
        else if (s4) fq4 <= 1'b1;
        else if (r4) fq4 <= 1'b0;
    end
    assign q_fb  = stuck ? 1'b0 : fq;
    assign q_fb4 = rnd_mode ? rnd_q : fq4;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Offer one target and watch until done/err; called 1 time unit after an edge
    task automatic do_txn(input bit t, input bit stk, output int lat, output bit e,
                          output int sc, output int rc);
        stuck = stk; tgt_d = t; tgt_valid = 1'b1;
        lat = -1; e = 1'b0; sc = 0; rc = 0;
        @(posedge clk); #1;
        tgt_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (s) sc++;
            if (r) rc++;
            if (done || err) begin
                lat = k; e = err;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        bit tgt;
        bit stk;
        int lat;
        bit is_err;
        bit mq;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  lat, sc, rc, exp_lat, exp_sc, exp_rc, exp_errs, nd;
        bit  e, mq, exp_e, qf, t, stk;

        tbl[0] = '{1'b1, 1'b0, 3, 1'b0, 1'b1};
        tbl[1] = '{1'b1, 1'b0, 1, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 1'b0, 3, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 6, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 1, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 3, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 3, 1'b0, 1'b0};

        rst = 1'b1; tgt_valid = 1'b0; tgt_d = 1'b0; stuck = 1'b0;
        rst4 = 1'b1; tgt_valid4 = 1'b0; tgt_d4 = 1'b0; rnd_mode = 1'b0; rnd_q = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; rst4 = 1'b0;
        chk("rst_s", s, 0);
        chk("rst_r", r, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_model_q", model_q, 0);
        chk("rst_tgt_ready", tgt_ready, 1);
        chk("rst_busy", busy, 0);

        // Directed transaction table
        mq = 1'b0; exp_errs = 0;
        foreach (tbl[i]) begin
            do_txn(tbl[i].tgt, tbl[i].stk, lat, e, sc, rc);
            exp_sc = (tbl[i].tgt != mq && tbl[i].tgt)  ? H : 0;
            exp_rc = (tbl[i].tgt != mq && !tbl[i].tgt) ? H : 0;
            if (tbl[i].is_err) exp_errs++;
            chk($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
            chk($sformatf("tbl%0d_err", i), e, tbl[i].is_err);
            chk($sformatf("tbl%0d_model_q", i), model_q, tbl[i].mq);
            chk($sformatf("tbl%0d_err_cnt", i), err_cnt, exp_errs);
            chk($sformatf("tbl%0d_s_cycles", i), sc, exp_sc);
            chk($sformatf("tbl%0d_r_cycles", i), rc, exp_rc);
            mq = tbl[i].mq;
        end

        // Randomized transactions against a latency/outcome model
        for (int n = 0; n < 150; n++) begin
            t   = 1'($urandom_range(0, 1));
            stk = ($urandom_range(0, 3) == 0);
            if (t == mq) begin
                exp_lat = 1; exp_e = 1'b0; exp_sc = 0; exp_rc = 0;
            end else begin
                exp_sc = t ? H : 0;
                exp_rc = t ? 0 : H;
                qf = stk ? 1'b0 : t;
                if (qf == t) begin
                    exp_lat = H + 2; exp_e = 1'b0; mq = t;
                end else begin
                    exp_lat = H + T + 1; exp_e = 1'b1; mq = qf;
                    if (exp_errs < 255) exp_errs++;
                end
            end
            do_txn(t, stk, lat, e, sc, rc);
            chk("rnd_lat", lat, exp_lat);
            chk("rnd_err", e, exp_e);
            chk("rnd_model_q", model_q, mq);
            chk("rnd_err_cnt", err_cnt, exp_errs);
            chk("rnd_s_cycles", sc, exp_sc);
            chk("rnd_r_cycles", rc, exp_rc);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        // Equal target offered on three consecutive edges
        do_txn(1'b1, 1'b0, lat, e, sc, rc);
        chk("eq_pre_model_q", model_q, 1);
        tgt_d = 1'b1; tgt_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("eq%0d_done", i), done, 1);
            chk($sformatf("eq%0d_s", i), s, 0);
            chk($sformatf("eq%0d_r", i), r, 0);
            chk($sformatf("eq%0d_tgt_ready", i), tgt_ready, 1);
        end
        tgt_valid = 1'b0;
        @(posedge clk); #1;
        chk("eq_done_drops", done, 0);

        // Saturation of err_cnt
        do_txn(1'b0, 1'b0, lat, e, sc, rc);
        chk("sat_pre_model_q", model_q, 0);
        for (int i = 0; i < 256; i++) begin
            do_txn(1'b1, 1'b1, lat, e, sc, rc);
            chk("sat_err", e, 1);
            if (exp_errs < 255) exp_errs++;
        end
        chk("sat_err_cnt", err_cnt, 255);
        chk("sat_err_cnt_model", err_cnt, exp_errs);
        chk("sat_model_q", model_q, 0);
        stuck = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("sat_rst_err_cnt", err_cnt, 0);

        // Reset while the H=4 instance is mid-DRIVE
        tgt_d4 = 1'b1; tgt_valid4 = 1'b1;
        @(posedge clk); #1;
        tgt_valid4 = 1'b0;
        chk("mid_s_c1", s4, 1);
        @(posedge clk); #1;
        chk("mid_s_c2", s4, 1);
        rst4 = 1'b1;
        @(posedge clk); #1;
        rst4 = 1'b0;
        chk("mid_s_after_rst", s4, 0);
        chk("mid_r_after_rst", r4, 0);
        chk("mid_busy", busy4, 0);
        chk("mid_tgt_ready", tgt_ready4, 1);
        chk("mid_model_q", model_q4, 0);
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            if (done4 || err4) nd++;
            @(posedge clk); #1;
        end
        chk("mid_no_done_err", nd, 0);

        // Random invariants with random feedback and resets
        rnd_mode = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            tgt_valid4 = 1'($urandom_range(0, 1));
            tgt_d4     = 1'($urandom_range(0, 1));
            rnd_q      = 1'($urandom_range(0, 1));
            rst4       = ($urandom_range(0, 31) == 0);
            @(posedge clk); #1;
            chk("inv_s_and_r", s4 & r4, 0);
            chk("inv_ready_and_busy", tgt_ready4 & busy4, 0);
            chk("inv_done_and_err", done4 & err4, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
